// File: rtl/des_pkg.sv
// Shared definitions for the DES key schedule: FSM encoding, per-round
// rotate amounts and the PC-2 selection table.
package des_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef enum logic {
      ROT_LEFT  = 1'b0,
      ROT_RIGHT = 1'b1
   } rot_dir_e;

   // Rounds 0, 1, 8 and 15 rotate by one position; every other round by two.
   localparam logic [15:0] SHIFT_ONE_MASK = 16'h8103;

   // PC-2 entries in FIPS numbering (1..56 over the concatenated C|D),
   // listed from output bit 1 to output bit 48.
   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Decrypt presents K16 first, which equals C0/D0, so its round 0 is unshifted.
   function automatic logic [1:0] round_shift(input logic [3:0] round, input logic dec);
      logic [1:0] amt;
      if (dec && (round == 4'd0)) begin
         amt = 2'd0;
      end else if (SHIFT_ONE_MASK[round]) begin
         amt = 2'd1;
      end else begin
         amt = 2'd2;
      end
      return amt;
   endfunction

endpackage

// File: rtl/ks_rot28.sv
// 28-bit circular rotate by 0, 1 or 2 positions in either direction.
module ks_rot28
   import des_pkg::*;
(
   input  logic [27:0] din,
   input  rot_dir_e    dir,
   input  logic [1:0]  amount,
   output logic [27:0] dout
);

   always_comb begin
      dout = din;
      case (amount)
         2'd1: begin
            if (dir == ROT_LEFT) dout = {din[26:0], din[27]};
            else                 dout = {din[0], din[27:1]};
         end
         2'd2: begin
            if (dir == ROT_LEFT) dout = {din[25:0], din[27:26]};
            else                 dout = {din[1:0], din[27:2]};
         end
         default: dout = din;
      endcase
   end

endmodule

// File: rtl/des_key_sched.sv
// DES subkey generator: rotates C/D per round and presents PC-2 of the
// registered halves with a valid/ready handshake, in either round order.
//
// state  | meaning
// IDLE   | waiting for start; C/D hold last value
// RUN    | subkey k_round presented, advances on k_valid & k_ready
// DONE   | one-cycle done pulse after round 15 was accepted
module des_key_sched
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        decrypt,
   input  logic [27:0] c_in,
   input  logic [27:0] d_in,
   input  logic        k_ready,
   output logic        k_valid,
   output logic [47:0] subkey,
   output logic [3:0]  k_round,
   output logic        busy,
   output logic        done
);

   state_e      state_q, state_d;
   logic [27:0] c_q, c_d;
   logic [27:0] d_q, d_d;
   logic [3:0]  round_q, round_d;
   logic        dec_q, dec_d;

   logic [27:0] c_src, d_src;
   logic [27:0] c_rot, d_rot;
   rot_dir_e    rot_dir;
   logic [1:0]  rot_amt;

   // In IDLE the rotators pre-shift the incoming key for round 0; in RUN
   // they compute the halves for the round that follows the current one.
   always_comb begin
      c_src   = c_q;
      d_src   = d_q;
      rot_dir = dec_q ? ROT_RIGHT : ROT_LEFT;
      rot_amt = round_shift(round_q + 4'd1, dec_q);
      if (state_q == S_IDLE) begin
         c_src   = c_in;
         d_src   = d_in;
         rot_dir = decrypt ? ROT_RIGHT : ROT_LEFT;
         rot_amt = round_shift(4'd0, decrypt);
      end
   end

   ks_rot28 u_rot_c (
      .din    (c_src),
      .dir    (rot_dir),
      .amount (rot_amt),
      .dout   (c_rot)
   );

   ks_rot28 u_rot_d (
      .din    (d_src),
      .dir    (rot_dir),
      .amount (rot_amt),
      .dout   (d_rot)
   );

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      round_d = round_q;
      dec_d   = dec_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dec_d   = decrypt;
               c_d     = c_rot;
               d_d     = d_rot;
               round_d = 4'd0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (k_ready) begin
               if (round_q == 4'd15) begin
                  state_d = S_DONE;
               end else begin
                  round_d = round_q + 4'd1;
                  c_d     = c_rot;
                  d_d     = d_rot;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
         dec_q   <= dec_d;
      end
   end

   // FIPS bit n of C|D lives at c_q[28-n] for n <= 28, else d_q[56-n].
   for (genvar i = 0; i < 48; i++) begin : g_pc2
      if (PC2_TBL[i] <= 28) begin : g_c
         assign subkey[47-i] = c_q[28-PC2_TBL[i]];
      end else begin : g_d
         assign subkey[47-i] = d_q[56-PC2_TBL[i]];
      end
   end

   assign k_valid = (state_q == S_RUN);
   assign busy    = (state_q == S_RUN);
   assign done    = (state_q == S_DONE);
   assign k_round = round_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched using the FIPS 46-3 worked example key.
module tb_des_key_sched;
   import des_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        decrypt;
   logic [27:0] c_in;
   logic [27:0] d_in;
   logic        k_ready;
   logic        k_valid;
   logic [47:0] subkey;
   logic [3:0]  k_round;
   logic        busy;
   logic        done;

   int total_cnt = 0;
   int pass_cnt  = 0;

   localparam logic [27:0] C0 = 28'hF0CCAAF;
   localparam logic [27:0] D0 = 28'h556678F;

   logic [47:0] ks_exp [16];

   des_key_sched dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .decrypt (decrypt),
      .c_in    (c_in),
      .d_in    (d_in),
      .k_ready (k_ready),
      .k_valid (k_valid),
      .subkey  (subkey),
      .k_round (k_round),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic launch(input logic dec);
      @(negedge clk);
      start = 1'b1; decrypt = dec; c_in = C0; d_in = D0;
      @(negedge clk);
      start = 1'b0; decrypt = 1'b0; c_in = '0; d_in = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (k_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || k_round !== 4'd0)
         $display("FAIL reset_outputs: got valid=%b busy=%b done=%b round=%0d want 0/0/0/0",
                  k_valid, busy, done, k_round);
      else pass_cnt++;
      total_cnt++;
      if (dut.c_q !== 28'd0 || dut.d_q !== 28'd0 || dut.dec_q !== 1'b0)
         $display("FAIL reset_cd: got c=%h d=%h dec=%b want 0/0/0", dut.c_q, dut.d_q, dut.dec_q);
      else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_encrypt();
      k_ready = 1'b1;
      launch(1'b0);
      for (int r = 0; r < 16; r++) begin
         total_cnt++;
         if (k_valid !== 1'b1 || done !== 1'b0 || k_round !== 4'(r) || subkey !== ks_exp[r])
            $display("FAIL enc_round%0d: got valid=%b done=%b round=%0d key=%h want 1/0/%0d/%h",
                     r, k_valid, done, k_round, subkey, r, ks_exp[r]);
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if (done !== 1'b1 || k_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL enc_done_at_17: got done=%b valid=%b busy=%b want 1/0/0", done, k_valid, busy);
      else pass_cnt++;
      total_cnt++;
      if (dut.c_q !== C0 || dut.d_q !== D0)
         $display("FAIL enc_cd_wrap: got c=%h d=%h want %h/%h", dut.c_q, dut.d_q, C0, D0);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0 || dut.state_q !== S_IDLE)
         $display("FAIL enc_done_pulse: got done=%b state=%0d want 0/IDLE", done, dut.state_q);
      else pass_cnt++;
   endtask

   task automatic test_decrypt_back_to_back();
      bit seen;
      k_ready = 1'b1;
      launch(1'b1);
      for (int r = 0; r < 16; r++) begin
         total_cnt++;
         if (k_valid !== 1'b1 || k_round !== 4'(r) || subkey !== ks_exp[15-r])
            $display("FAIL dec_round%0d: got valid=%b round=%0d key=%h want 1/%0d/%h",
                     r, k_valid, k_round, subkey, r, ks_exp[15-r]);
         else pass_cnt++;
         @(negedge clk);
      end
      // start held from the DONE cycle on: ignored in DONE, taken in IDLE
      start = 1'b1; decrypt = 1'b0; c_in = C0; d_in = D0;
      total_cnt++;
      if (done !== 1'b1)
         $display("FAIL dec_done: got done=%b want 1", done);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (k_valid !== 1'b0 || done !== 1'b0)
         $display("FAIL b2b_start_in_done: got valid=%b done=%b want 0/0", k_valid, done);
      else pass_cnt++;
      @(negedge clk);
      start = 1'b0; c_in = '0; d_in = '0;
      total_cnt++;
      if (k_valid !== 1'b1 || k_round !== 4'd0 || subkey !== ks_exp[0])
         $display("FAIL b2b_round0: got valid=%b round=%0d key=%h want 1/0/%h",
                  k_valid, k_round, subkey, ks_exp[0]);
      else pass_cnt++;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      total_cnt++;
      if (!seen) $display("FAIL b2b_drain: got done=0 within 40 cycles want done=1");
      else pass_cnt++;
   endtask

   task automatic test_stall();
      k_ready = 1'b1;
      launch(1'b0);
      for (int r = 0; r < 16; r++) begin
         total_cnt++;
         if (k_valid !== 1'b1 || k_round !== 4'(r) || subkey !== ks_exp[r])
            $display("FAIL stall_round%0d: got round=%0d key=%h want %0d/%h",
                     r, k_round, subkey, r, ks_exp[r]);
         else pass_cnt++;
         if (r == 3) begin
            k_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               total_cnt++;
               if (k_valid !== 1'b1 || k_round !== 4'd3 || subkey !== ks_exp[3])
                  $display("FAIL stall_hold%0d: got valid=%b round=%0d key=%h want 1/3/%h",
                           s, k_valid, k_round, subkey, ks_exp[3]);
               else pass_cnt++;
            end
            k_ready = 1'b1;
         end
         @(negedge clk);
      end
      total_cnt++;
      if (done !== 1'b1)
         $display("FAIL stall_done: got done=%b want 1", done);
      else pass_cnt++;
   endtask

   task automatic test_start_ignored();
      k_ready = 1'b1;
      launch(1'b0);
      for (int r = 0; r < 16; r++) begin
         total_cnt++;
         if (k_valid !== 1'b1 || k_round !== 4'(r) || subkey !== ks_exp[r])
            $display("FAIL busy_start_round%0d: got round=%0d key=%h want %0d/%h",
                     r, k_round, subkey, r, ks_exp[r]);
         else pass_cnt++;
         if (r == 7) begin
            start = 1'b1; decrypt = 1'b1; c_in = 28'h1234567; d_in = 28'h7654321;
         end
         @(negedge clk);
         start = 1'b0; decrypt = 1'b0; c_in = '0; d_in = '0;
      end
      total_cnt++;
      if (done !== 1'b1)
         $display("FAIL busy_start_done: got done=%b want 1", done);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit seen;
      k_ready = 1'b1;
      launch(1'b0);
      for (int r = 0; r < 9; r++) @(negedge clk);
      total_cnt++;
      if (k_round !== 4'd9 || subkey !== ks_exp[9])
         $display("FAIL rstmid_round9: got round=%0d key=%h want 9/%h", k_round, subkey, ks_exp[9]);
      else pass_cnt++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total_cnt++;
      if (k_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || k_round !== 4'd0 ||
          dut.state_q !== S_IDLE)
         $display("FAIL rstmid_idle: got valid=%b busy=%b done=%b round=%0d state=%0d want 0/0/0/0/IDLE",
                  k_valid, busy, done, k_round, dut.state_q);
      else pass_cnt++;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) seen = 1'b1;
      end
      total_cnt++;
      if (seen) $display("FAIL rstmid_no_done: got done=1 after reset want 0");
      else pass_cnt++;
      launch(1'b0);
      total_cnt++;
      if (k_valid !== 1'b1 || k_round !== 4'd0 || subkey !== ks_exp[0])
         $display("FAIL rstmid_restart: got valid=%b round=%0d key=%h want 1/0/%h",
                  k_valid, k_round, subkey, ks_exp[0]);
      else pass_cnt++;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      total_cnt++;
      if (!seen) $display("FAIL rstmid_drain: got done=0 within 40 cycles want done=1");
      else pass_cnt++;
   endtask

   initial begin
      ks_exp = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                 48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                 48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                 48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
      rst = 1'b1; start = 1'b0; decrypt = 1'b0; c_in = '0; d_in = '0; k_ready = 1'b0;
      test_reset();
      test_encrypt();
      test_decrypt_back_to_back();
      test_stall();
      test_start_ignored();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
